// File: rtl/rgb_pwm_driver.sv
// Tri-colour PWM driver: double-buffered 24-bit RGB code applied on PWM period boundaries.
// Outputs are registered one clk behind the duty counter; no backpressure, a newer code overwrites the pending one.
module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rgb_valid,
  input  logic [23:0] rgb,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start,
  output logic        update_ack
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [23:0]   pending_q, pending_d;
  logic          pend_flag_q, pend_flag_d;
  logic          pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
  logic          frame_q, frame_d, ack_q, ack_d;
  logic          tick, boundary;

  assign tick     = enable && (pre_q == PRE_MAX);
  assign boundary = tick && (cnt_q == 8'hFF);

  always_comb begin
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    duty_r_d    = duty_r_q;
    duty_g_d    = duty_g_q;
    duty_b_d    = duty_b_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    ack_d       = 1'b0;
    frame_d     = boundary;

    if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 8'd1;
    end else if (enable) begin
      pre_d = pre_q + 1'b1;
    end

    if (boundary && pend_flag_q) begin
      duty_r_d    = pending_q[23:16];
      duty_g_d    = pending_q[15:8];
      duty_b_d    = pending_q[7:0];
      pend_flag_d = 1'b0;
      ack_d       = 1'b1;
    end

    // A code arriving on the boundary cycle waits for the next boundary.
    if (rgb_valid) begin
      pending_d   = rgb;
      pend_flag_d = 1'b1;
    end

    pwm_r_d = enable && (cnt_q < duty_r_q);
    pwm_g_d = enable && (cnt_q < duty_g_q);
    pwm_b_d = enable && (cnt_q < duty_b_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q       <= '0;
      cnt_q       <= '0;
      duty_r_q    <= '0;
      duty_g_q    <= '0;
      duty_b_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      pwm_r_q     <= 1'b0;
      pwm_g_q     <= 1'b0;
      pwm_b_q     <= 1'b0;
      frame_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      duty_r_q    <= duty_r_d;
      duty_g_q    <= duty_g_d;
      duty_b_q    <= duty_b_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      pwm_r_q     <= pwm_r_d;
      pwm_g_q     <= pwm_g_d;
      pwm_b_q     <= pwm_b_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
    end
  end

  assign pwm_r       = pwm_r_q;
  assign pwm_g       = pwm_g_q;
  assign pwm_b       = pwm_b_q;
  assign frame_start = frame_q;
  assign update_ack  = ack_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: PRESCALE=1 instance for most steps, PRESCALE=4 instance for period scaling.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n, enable, rgb_valid;
  logic [23:0] rgb;
  logic        pwm_r1, pwm_g1, pwm_b1, fs1, ack1;
  logic        pwm_r4, pwm_g4, pwm_b4, fs4, ack4;

  int checks = 0;
  int errors = 0;
  int cyc, acks, hi, r, g, b, fsn;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb_valid(rgb_valid), .rgb(rgb),
    .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1), .frame_start(fs1), .update_ack(ack1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb_valid(rgb_valid), .rgb(rgb),
    .pwm_r(pwm_r4), .pwm_g(pwm_g4), .pwm_b(pwm_b4), .frame_start(fs4), .update_ack(ack4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [23:0] v);
    rgb       = v;
    rgb_valid = 1'b1;
    @(negedge clk);
    rgb_valid = 1'b0;
  endtask

  // Cycles up to and including the next frame_start; cyc = -1 on timeout.
  task automatic wait_fs(input bit big, input int limit,
                         output int c, output int a, output int h);
    c = 0; a = 0; h = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      c++;
      if (big) begin
        a += int'(ack4); h += int'(pwm_r4);
        if (fs4) return;
      end else begin
        a += int'(ack1); h += int'(pwm_r1);
        if (fs1) return;
      end
    end
    c = -1;
  endtask

  // Starting on a frame_start cycle: samples one full period of PWM output.
  task automatic count_period(input bit big, output int cr, output int cg,
                              output int cb, output int a, output int f);
    int n;
    n = big ? 1024 : 256;
    cr = 0; cg = 0; cb = 0; a = 0; f = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (big) begin
        cr += int'(pwm_r4); cg += int'(pwm_g4); cb += int'(pwm_b4);
        a += int'(ack4); f += int'(fs4);
      end else begin
        cr += int'(pwm_r1); cg += int'(pwm_g1); cb += int'(pwm_b1);
        a += int'(ack1); f += int'(fs1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; rgb_valid = 1'b0; rgb = '0;

    // 1: reset
    step(3);
    check("t1_outs1", int'({pwm_r1, pwm_g1, pwm_b1, fs1, ack1}), 0);
    check("t1_outs4", int'({pwm_r4, pwm_g4, pwm_b4, fs4, ack4}), 0);
    check("t1_cnt", int'(dut1.cnt_q), 0);
    rst_n = 1'b1;
    wait_fs(1'b0, 400, cyc, acks, hi);
    check("t1_first_frame", cyc, 256);
    check("t1_no_ack", acks, 0);

    // 2: single update mid-period
    step(50);
    pulse(24'hFF8000);
    wait_fs(1'b0, 300, cyc, acks, hi);
    check("t2_ack_at_frame", int'(ack1), 1);
    check("t2_ack_count", acks, 1);
    count_period(1'b0, r, g, b, acks, fsn);
    check("t2_r", r, 255);
    check("t2_g", g, 128);
    check("t2_b", b, 0);
    check("t2_no_ack", acks, 0);
    check("t2_fs", fsn, 1);

    // 3: last valid in a period wins
    step(10);
    pulse(24'h00FF00);
    step(10);
    pulse(24'h0000FF);
    wait_fs(1'b0, 300, cyc, acks, hi);
    check("t3_ack_count", acks, 1);
    count_period(1'b0, r, g, b, acks, fsn);
    check("t3_r", r, 0);
    check("t3_g", g, 0);
    check("t3_b", b, 255);

    // 4: valid on the boundary cycle defers to the next boundary
    step(10);
    pulse(24'h101010);
    step(244);
    rgb = 24'h202020; rgb_valid = 1'b1;
    @(negedge clk);
    rgb_valid = 1'b0;
    check("t4_fs", int'(fs1), 1);
    check("t4_ack1", int'(ack1), 1);
    count_period(1'b0, r, g, b, acks, fsn);
    check("t4_r10", r, 16);
    check("t4_b10", b, 16);
    check("t4_ack2", acks, 1);
    count_period(1'b0, r, g, b, acks, fsn);
    check("t4_g20", g, 32);
    check("t4_ack_none", acks, 0);

    // 5: enable drop at cnt=100
    step(20);
    pulse(24'hFFFFFF);
    wait_fs(1'b0, 300, cyc, acks, hi);
    check("t5_ack", acks, 1);
    step(100);
    check("t5_pre_high", int'(pwm_r1), 1);
    enable = 1'b0;
    @(negedge clk);
    check("t5_off", int'({pwm_r1, pwm_g1, pwm_b1}), 0);
    hi = 0; fsn = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      hi += int'(pwm_r1 | pwm_g1 | pwm_b1);
      fsn += int'(fs1);
    end
    check("t5_hold_low", hi, 0);
    check("t5_no_fs", fsn, 0);
    check("t5_cnt_held", int'(dut1.cnt_q), 100);
    enable = 1'b1;
    wait_fs(1'b0, 300, cyc, acks, hi);
    check("t5_resume_len", cyc, 156);
    check("t5_resume_high", hi, 155);

    // 7: reset mid-period discards pending code
    step(10);
    pulse(24'h123456);
    step(189);
    check("t7_pre_high", int'(pwm_r1), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_outs", int'({pwm_r1, pwm_g1, pwm_b1, fs1, ack1}), 0);
    check("t7_cnt", int'(dut1.cnt_q), 0);
    rst_n = 1'b1;
    wait_fs(1'b0, 300, cyc, acks, hi);
    check("t7_frame", cyc, 256);
    check("t7_no_ack", acks, 0);
    count_period(1'b0, r, g, b, acks, fsn);
    check("t7_duty_cleared", r + g + b, 0);

    // 6: PRESCALE=4
    pulse(24'h404040);
    wait_fs(1'b1, 1500, cyc, acks, hi);
    check("t6_found", int'(cyc > 0), 1);
    check("t6_ack", acks, 1);
    count_period(1'b1, r, g, b, acks, fsn);
    check("t6_r", r, 256);
    check("t6_b", b, 256);
    check("t6_fs_spacing", fsn, 1);
    check("t6_fs_at_end", int'(fs4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
